maccum_back: RTL and testbench

- Backward-pass counterpart of the forward multiply-accumulate layer.
- Accepts a weight matrix W[NC][NP] and a child-side delta vector D[NC]. Produces the parent-side back-propagated sums B[p] = sum over c of W[c][p]*D[c].
- Time-multiplexed: NP parallel multipliers, iterating over NC over NC cycles.
- Sits between a layer's delta generator and the previous layer's delta/weight-update stage. Valid/ready on every port.

---
 rtl/maccum_back.sv | 143 ++++++++++++++
 tb/tb_maccum_back.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maccum_back.sv
// maccum_back: backward-pass multiply-accumulate.
// Computes B[p] = sum over c of W[c][p] * D[c] with NP parallel multipliers,
// walking over the NC child neurons one per cycle.
// Optional build macro: MACCUM_BACK_ROUND_EN selects round-half-up on each
// product term instead of truncation toward -inf.
module maccum_back #(
    parameter int NP = 4,
    parameter int NC = 4,
    parameter int WF = 8,
    localparam int WO = $clog2(NC) + WF
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iValid_AM_Weight,
    output logic                   oReady_AM_Weight,
    input  logic [NC*NP*WF-1:0]    iData_AM_Weight,
    input  logic                   iValid_AM_Delta,
    output logic                   oReady_AM_Delta,
    input  logic [NC*WF-1:0]       iData_AM_Delta,
    output logic                   oValid_BM_Back,
    input  logic                   iReady_BM_Back,
    output logic [NP*WO-1:0]       oData_BM_Back
);

    localparam int CW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]          step;
    logic [NC*NP*WF-1:0]    w_lat;
    logic [NC*WF-1:0]       d_lat;
    logic signed [WO-1:0]   acc [NP];

    logic                   in_fire;
    logic                   last_step;

    logic signed [WF-1:0]   d_op;
    logic signed [WF-1:0]   w_op [NP];
    logic signed [2*WF-1:0] prod [NP];
    logic signed [WF-1:0]   term [NP];

`ifdef MACCUM_BACK_ROUND_EN
    localparam logic signed [2*WF:0] RND_BIAS = (2*WF+1)'(2**(WF-2));
    logic signed [2*WF:0]   rnd [NP];
`endif

    assign in_fire   = (state == IDLE) && iValid_AM_Weight && iValid_AM_Delta;
    assign last_step = (step == CW'(NC - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: joint input handshake, NC accumulate steps, hold until drained.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_fire)        state_next = ACCUM;
            ACCUM:   if (last_step)      state_next = DONE;
            DONE:    if (iReady_BM_Back) state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Outputs: readies cross-coupled so both inputs transfer together; data only shown in DONE.
    always_comb begin
        oReady_AM_Weight = 1'b0;
        oReady_AM_Delta  = 1'b0;
        oValid_BM_Back   = 1'b0;
        oData_BM_Back    = '0;
        if (!iRST && state == IDLE) begin
            oReady_AM_Weight = iValid_AM_Delta;
            oReady_AM_Delta  = iValid_AM_Weight;
        end
        if (state == DONE) begin
            oValid_BM_Back = 1'b1;
            for (int p = 0; p < NP; p++) begin
                oData_BM_Back[p*WO +: WO] = acc[p];
            end
        end
    end

    // Per-column product of the current row of W with D[step], scaled back to Q1.(WF-1).
    always_comb begin
        d_op = d_lat[int'(step)*WF +: WF];
        for (int p = 0; p < NP; p++) begin
            w_op[p] = w_lat[(int'(step)*NP + p)*WF +: WF];
            prod[p] = w_op[p] * d_op;
`ifdef MACCUM_BACK_ROUND_EN
            rnd[p]  = (2*WF+1)'(prod[p]) + RND_BIAS;
            term[p] = WF'(rnd[p] >>> (WF - 1));
`else
            term[p] = WF'(prod[p] >>> (WF - 1));
`endif
        end
    end

    // Datapath: latch operands on the joint handshake, then add one sign-extended term per step.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            step  <= '0;
            w_lat <= '0;
            d_lat <= '0;
            for (int p = 0; p < NP; p++) begin
                acc[p] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        w_lat <= iData_AM_Weight;
                        d_lat <= iData_AM_Delta;
                        step  <= '0;
                        for (int p = 0; p < NP; p++) begin
                            acc[p] <= '0;
                        end
                    end
                end
                ACCUM: begin
                    for (int p = 0; p < NP; p++) begin
                        acc[p] <= acc[p] + WO'(term[p]);
                    end
                    step <= last_step ? '0 : step + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maccum_back.sv
// tb_maccum_back: scoreboard bench for maccum_back (NP=4, NC=4, WF=8).
// Expected sums are hand-computed; rounding-dependent values follow
// MACCUM_BACK_ROUND_EN.
module tb_maccum_back;

    localparam int NP = 4;
    localparam int NC = 4;
    localparam int WF = 8;
    localparam int WO = $clog2(NC) + WF;
    localparam int OW = NP * WO;

    logic                 iCLK;
    logic                 iRST;
    logic                 iValid_AM_Weight;
    logic                 oReady_AM_Weight;
    logic [NC*NP*WF-1:0]  iData_AM_Weight;
    logic                 iValid_AM_Delta;
    logic                 oReady_AM_Delta;
    logic [NC*WF-1:0]     iData_AM_Delta;
    logic                 oValid_BM_Back;
    logic                 iReady_BM_Back;
    logic [OW-1:0]        oData_BM_Back;

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] exp_q [$];

    maccum_back #(.NP(NP), .NC(NC), .WF(WF)) dut (
        .iCLK             (iCLK),
        .iRST             (iRST),
        .iValid_AM_Weight (iValid_AM_Weight),
        .oReady_AM_Weight (oReady_AM_Weight),
        .iData_AM_Weight  (iData_AM_Weight),
        .iValid_AM_Delta  (iValid_AM_Delta),
        .oReady_AM_Delta  (oReady_AM_Delta),
        .iData_AM_Delta   (iData_AM_Delta),
        .oValid_BM_Back   (oValid_BM_Back),
        .iReady_BM_Back   (iReady_BM_Back),
        .oData_BM_Back    (oData_BM_Back)
    );

    // Free-running 100 MHz clock.
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] allLanes(input logic [WO-1:0] v);
        return {NP{v}};
    endfunction

    // Present both operands together; expected result queued when requested.
    task automatic applyStimulus(input logic [NC*NP*WF-1:0] w, input logic [NC*WF-1:0] d,
                                 input logic [OW-1:0] exp, input bit push);
        iData_AM_Weight  = w;
        iData_AM_Delta   = d;
        iValid_AM_Weight = 1'b1;
        iValid_AM_Delta  = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge iCLK);
        checkOutput("idle_ready_w", oReady_AM_Weight, 1);
        checkOutput("idle_ready_d", oReady_AM_Delta, 1);
        @(posedge iCLK);
        #1;
        iData_AM_Weight = {$urandom, $urandom, $urandom, $urandom};
        iData_AM_Delta  = $urandom;
    endtask

    // Count cycles from the input handshake to oValid; bounded.
    task automatic waitResult();
        int  n = 0;
        bit  seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge iCLK);
            n++;
            if (n == 2) begin
                checkOutput("accum_ready_w", oReady_AM_Weight, 0);
                checkOutput("accum_ready_d", oReady_AM_Delta, 0);
            end
            if (oValid_BM_Back) seen = 1'b1;
        end
        checkOutput("result_latency", seen ? n : 0, NC + 1);
        iValid_AM_Weight = 1'b0;
        iValid_AM_Delta  = 1'b0;
        if (seen && iReady_BM_Back) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    // Monitor: every output handshake pops one expected result.
    initial begin
        logic [OW-1:0] e;
        forever begin
            @(negedge iCLK);
            if (!iRST && oValid_BM_Back && iReady_BM_Back) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("result_data", 64'(oData_BM_Back), 64'(e));
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        logic [OW-1:0] exp_var;
        logic [OW-1:0] exp_rnd;
        iRST             = 1'b1;
        iValid_AM_Weight = 1'b1;
        iValid_AM_Delta  = 1'b1;
        iData_AM_Weight  = '0;
        iData_AM_Delta   = '0;
        iReady_BM_Back   = 1'b1;

        #2;
        checkOutput("rst_ready_w", oReady_AM_Weight, 0);
        checkOutput("rst_ready_d", oReady_AM_Delta, 0);
        checkOutput("rst_valid", oValid_BM_Back, 0);
        checkOutput("rst_data", 64'(oData_BM_Back), 0);
        iValid_AM_Delta = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        iRST = 1'b0;

        // Lone weight valid must never be consumed.
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLK);
            checkOutput("lone_w_ready_d", oReady_AM_Delta, 1);
            checkOutput("lone_w_ready_w", oReady_AM_Weight, 0);
            checkOutput("lone_w_valid", oValid_BM_Back, 0);
        end
        @(posedge iCLK);
        #1;
        iValid_AM_Weight = 1'b0;
        iValid_AM_Delta  = 1'b1;
        @(negedge iCLK);
        checkOutput("lone_d_ready_w", oReady_AM_Weight, 1);
        checkOutput("lone_d_ready_d", oReady_AM_Delta, 0);
        checkOutput("idle_data", 64'(oData_BM_Back), 0);
        @(posedge iCLK);
        #1;
        iValid_AM_Delta = 1'b0;

        // Basic: 0.5*0.5 four times = 1.0.
        applyStimulus({16{8'h40}}, {4{8'h40}}, allLanes(10'h080), 1);
        waitResult();

        // Signed: -0.5*0.5 four times = -1.0.
        applyStimulus({16{8'hC0}}, {4{8'h40}}, allLanes(10'h380), 1);
        waitResult();

        // Mixed rows cancel.
        applyStimulus(128'hC0C0C0C0_40404040_C0C0C0C0_40404040, {4{8'h40}}, allLanes(10'h000), 1);
        waitResult();

        // Small product: truncates to zero or rounds to one per step.
`ifdef MACCUM_BACK_ROUND_EN
        exp_rnd = allLanes(10'h004);
`else
        exp_rnd = allLanes(10'h000);
`endif
        applyStimulus({16{8'h01}}, {4{8'h40}}, exp_rnd, 1);
        waitResult();

        // -1 * -1 wraps to -1 each step: sum -4 = 0x200.
        applyStimulus({16{8'h80}}, {4{8'h80}}, allLanes(10'h200), 1);
        waitResult();

        // Per-column distinct weights, per-row distinct deltas.
`ifdef MACCUM_BACK_ROUND_EN
        exp_var = {10'd112, 10'd84, 10'd56, 10'd28};
`else
        exp_var = {10'd111, 10'd83, 10'd55, 10'd27};
`endif
        applyStimulus({4{32'h40302010}}, 32'h7F002040, exp_var, 1);
        waitResult();

        // Backpressure: hold DONE for 6 cycles with a new request waiting.
        iReady_BM_Back = 1'b0;
        applyStimulus({16{8'h40}}, {4{8'h40}}, allLanes(10'h080), 1);
        waitResult();
        @(posedge iCLK);
        #1;
        iData_AM_Weight  = {16{8'hC0}};
        iData_AM_Delta   = {4{8'h40}};
        iValid_AM_Weight = 1'b1;
        iValid_AM_Delta  = 1'b1;
        exp_q.push_back(allLanes(10'h380));
        for (int i = 0; i < 6; i++) begin
            @(negedge iCLK);
            checkOutput("stall_valid", oValid_BM_Back, 1);
            checkOutput("stall_data", 64'(oData_BM_Back), 64'(allLanes(10'h080)));
            checkOutput("stall_ready_w", oReady_AM_Weight, 0);
            checkOutput("stall_ready_d", oReady_AM_Delta, 0);
        end
        @(posedge iCLK);
        #1;
        iReady_BM_Back = 1'b1;
        @(negedge iCLK);
        checkOutput("out_hs_ready_w", oReady_AM_Weight, 0);
        checkOutput("out_hs_ready_d", oReady_AM_Delta, 0);
        @(posedge iCLK);
        #1;
        @(negedge iCLK);
        checkOutput("after_hs_ready_w", oReady_AM_Weight, 1);
        checkOutput("after_hs_ready_d", oReady_AM_Delta, 1);
        @(posedge iCLK);
        #1;
        iData_AM_Weight = {$urandom, $urandom, $urandom, $urandom};
        iData_AM_Delta  = $urandom;
        waitResult();

        // Reset during ACCUM discards the run.
        applyStimulus({16{8'h7F}}, {4{8'h7F}}, '0, 0);
        @(negedge iCLK);
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        #1;
        checkOutput("abort_valid", oValid_BM_Back, 0);
        checkOutput("abort_data", 64'(oData_BM_Back), 0);
        checkOutput("abort_ready_w", oReady_AM_Weight, 0);
        checkOutput("abort_ready_d", oReady_AM_Delta, 0);
        @(posedge iCLK);
        #1;
        iRST             = 1'b0;
        iValid_AM_Weight = 1'b0;
        iValid_AM_Delta  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge iCLK);
            checkOutput("post_abort_valid", oValid_BM_Back, 0);
        end
        @(posedge iCLK);
        #1;
        applyStimulus({16{8'h40}}, {4{8'h40}}, allLanes(10'h080), 1);
        waitResult();

        repeat (3) @(posedge iCLK);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
